// File: rtl/digest_out_buf.sv
// Staging buffer between the BLAKE2s digest byte stream and the host pins:
// captures up to MAX_BYTES bytes, then replays them one per host read strobe.
module digest_out_buf #(
  parameter int MAX_BYTES = 32,
  parameter int IDX_W     = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] nn_i,
  input  logic       h_v_i,
  input  logic [7:0] h_i,
  input  logic       rd_i,
  output logic       hash_v_o,
  output logic [7:0] hash_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       ovf_o
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  localparam logic [5:0]       MAX_NN   = 6'(MAX_BYTES);
  localparam logic [IDX_W-1:0] LAST_MAX = IDX_W'(MAX_BYTES - 1);
  localparam logic [IDX_W-1:0] IDX0     = '0;

  state_t           state_q;
  logic [IDX_W-1:0] wr_cnt_q;
  logic [IDX_W-1:0] rd_ptr_q;
  logic [IDX_W-1:0] last_q;
  logic             hash_v_q;
  logic [7:0]       hash_q;
  logic             busy_q;
  logic             done_q;
  logic             ovf_q;

  logic [7:0]       mem_q [MAX_BYTES];
  logic [IDX_W-1:0] nn_last_d;
  logic             wr_en_d;

  // Length is stored as the index of the final byte so it fits the pointer width.
  always_comb begin
    nn_last_d = LAST_MAX;
    if (nn_i != 6'd0 && nn_i <= MAX_NN) begin
      nn_last_d = IDX_W'(nn_i - 6'd1);
    end
  end

  assign wr_en_d = h_v_i && (state_q != DRAIN);

  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      mem_q[wr_cnt_q] <= h_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_cnt_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
      hash_v_q <= 1'b0;
      hash_q   <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (h_v_i && state_q == DRAIN) begin
        ovf_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (h_v_i) begin
            last_q   <= nn_last_d;
            busy_q   <= 1'b1;
            wr_cnt_q <= IDX_W'(1);
            if (nn_last_d == IDX0) begin
              // Single-byte digest: the byte is not in memory yet, present it directly.
              state_q  <= DRAIN;
              hash_v_q <= 1'b1;
              hash_q   <= h_i;
            end else begin
              state_q <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (h_v_i) begin
            if (wr_cnt_q == last_q) begin
              state_q  <= DRAIN;
              hash_v_q <= 1'b1;
              hash_q   <= mem_q[IDX0];
            end else begin
              wr_cnt_q <= wr_cnt_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (rd_i) begin
            if (rd_ptr_q == last_q) begin
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              hash_v_q <= 1'b0;
              done_q   <= 1'b1;
              rd_ptr_q <= '0;
              wr_cnt_q <= '0;
            end else begin
              rd_ptr_q <= rd_ptr_q + 1'b1;
              hash_q   <= mem_q[rd_ptr_q + 1'b1];
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign hash_v_o = hash_v_q;
  assign hash_o   = hash_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign ovf_o    = ovf_q;

endmodule
